// File: rtl/sec_ctrl_pkg.sv
// Shared types and widths for the SEC scrub controller.
package sec_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CHK_W     = 8;
    localparam int unsigned WORD_W    = 40;
    localparam int unsigned FIX_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CHK,
        WB
    } state_e;

endpackage

// File: rtl/sec_scrub_timer.sv
// Scrub interval timer, one-deep pending flag and wrapping scrub-address walker.
module sec_scrub_timer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned SCRUB_INT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scrub_grant_i,
    input  logic              scrub_done_i,
    output logic              scrub_pend_o,
    output logic [ADDR_W-1:0] scrub_addr_o
);

    localparam int unsigned       CntW    = $clog2(SCRUB_INT);
    localparam logic [CntW-1:0]   CntMax  = CntW'(SCRUB_INT - 1);
    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(DEPTH - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap;

    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        // A wrap while already pending is simply absorbed: no request queueing.
        if (scrub_grant_i) begin
            pend_d = 1'b0;
        end else if (wrap) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        addr_d = addr_q;
        if (scrub_done_i) begin
            addr_d = (addr_q == AddrMax) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            addr_q <= addr_d;
        end
    end

    assign scrub_pend_o = pend_q;
    assign scrub_addr_o = addr_q;

endmodule

// File: rtl/sec_scrub_ctrl.sv
// Sequencer/arbiter sharing one external SEC corrector between host reads and a
// background scrubber; corrected scrub words are written back.
module sec_scrub_ctrl
    import sec_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 8,
    parameter int unsigned          DEPTH     = 256,
    parameter int unsigned          SCRUB_INT = 1024,
    // Reset value of the fix counter; 0 in normal use.
    parameter logic [FIX_CNT_W-1:0] FIX_INIT  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 host_req_i,
    input  logic [ADDR_W-1:0]    host_addr_i,
    output logic                 host_gnt_o,
    output logic                 host_rvalid_o,
    output logic [DATA_W-1:0]    host_rdata_o,
    output logic                 host_corr_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [WORD_W-1:0]    mem_wdata_o,
    input  logic [WORD_W-1:0]    mem_rdata_i,
    output logic [DATA_W-1:0]    sec_id_o,
    output logic [CHK_W-1:0]     sec_ic_o,
    output logic                 sec_r_o,
    input  logic [DATA_W-1:0]    sec_od_i,
    output logic [FIX_CNT_W-1:0] scrub_fixes_o
);

    state_e               state_q;
    logic                 last_host_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 mem_re_q, mem_we_q, host_rvalid_q, host_corr_q;
    logic [DATA_W-1:0]    host_rdata_q;
    logic [WORD_W-1:0]    mem_wdata_q;
    logic [FIX_CNT_W-1:0] fixes_q;

    logic                 scrub_pend, scrub_win, host_win, scrub_done, corr, in_chk;
    logic [ADDR_W-1:0]    scrub_addr;

    sec_scrub_timer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .SCRUB_INT(SCRUB_INT)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .scrub_grant_i(scrub_win),
        .scrub_done_i (scrub_done),
        .scrub_pend_o (scrub_pend),
        .scrub_addr_o (scrub_addr)
    );

    // Alternate on contention so neither side waits more than one access.
    assign scrub_win  = (state_q == IDLE) && scrub_pend && (last_host_q || !host_req_i);
    assign host_win   = (state_q == IDLE) && host_req_i && !scrub_win;
    assign in_chk     = (state_q == CHK);
    assign scrub_done = in_chk && !last_host_q;
    assign corr       = (sec_od_i != mem_rdata_i[DATA_W-1:0]);

    // Read data only arrives in CHK, so the corrector inputs are gated by the state.
    assign sec_r_o  = in_chk;
    assign sec_id_o = in_chk ? mem_rdata_i[DATA_W-1:0] : '0;
    assign sec_ic_o = in_chk ? mem_rdata_i[WORD_W-1:DATA_W] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            last_host_q   <= 1'b0;
            addr_q        <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            host_corr_q   <= 1'b0;
            fixes_q       <= FIX_INIT;
        end else begin
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            host_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (scrub_win) begin
                        state_q     <= RD;
                        last_host_q <= 1'b0;
                        addr_q      <= scrub_addr;
                        mem_re_q    <= 1'b1;
                    end else if (host_win) begin
                        state_q     <= RD;
                        last_host_q <= 1'b1;
                        addr_q      <= host_addr_i;
                        mem_re_q    <= 1'b1;
                    end
                end
                RD: state_q <= CHK;
                CHK: begin
                    if (last_host_q) begin
                        state_q       <= IDLE;
                        host_rvalid_q <= 1'b1;
                        host_rdata_q  <= sec_od_i;
                        host_corr_q   <= corr;
                    end else if (corr) begin
                        // Check bits go back unchanged; only data bits are corrected.
                        state_q     <= WB;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {mem_rdata_i[WORD_W-1:DATA_W], sec_od_i};
                        if (fixes_q != '1) begin
                            fixes_q <= fixes_q + 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host_gnt_o    = host_win;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_corr_o   = host_corr_q;
    assign mem_re_o      = mem_re_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign scrub_fixes_o = fixes_q;

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Self-checking bench for sec_scrub_ctrl: behavioural memory + corrector, scoreboard monitor,
// table-driven host reads, randomized traffic and a reset-in-CHK sequence.
module tb_sec_scrub_ctrl;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned SCRUB_INT = 16;
    localparam logic [15:0] FIX_INIT  = 16'hFFF8;

    logic        clk, rst_n;
    logic        host_req, host_gnt, host_rvalid, host_corr;
    logic [7:0]  host_addr, mem_addr;
    logic [31:0] host_rdata, sec_id, sec_od;
    logic        mem_re, mem_we, sec_r;
    logic [39:0] mem_wdata, mem_rdata;
    logic [7:0]  sec_ic;
    logic [15:0] scrub_fixes;

    sec_scrub_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .SCRUB_INT(SCRUB_INT),
        .FIX_INIT (FIX_INIT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_req_i   (host_req),
        .host_addr_i  (host_addr),
        .host_gnt_o   (host_gnt),
        .host_rvalid_o(host_rvalid),
        .host_rdata_o (host_rdata),
        .host_corr_o  (host_corr),
        .mem_re_o     (mem_re),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .sec_id_o     (sec_id),
        .sec_ic_o     (sec_ic),
        .sec_r_o      (sec_r),
        .sec_od_i     (sec_od),
        .scrub_fixes_o(scrub_fixes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Bench corrector: check bit 7 flags a single error at data bit check[4:0].
    function automatic logic [31:0] fix_word(input logic [31:0] d, input logic [7:0] c);
        logic [31:0] r;
        r = d;
        if (c[7]) r[c[4:0]] = ~r[c[4:0]];
        return r;
    endfunction

    assign sec_od = fix_word(sec_id, sec_ic);

    // Memory: read data one cycle after mem_re; bench preload via tb_wr_*.
    logic [39:0] mem    [256];
    logic [39:0] shadow [256];
    logic        tb_wr_en = 1'b0;
    logic [7:0]  tb_wr_addr = '0;
    logic [39:0] tb_wr_data = '0;

    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard monitor: predicts every access from the reference memory image.
    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        corr;
    } host_t;

    host_t       hq[$];
    host_t       hnew, hcur;
    int          wrap_q[$];
    int          n_scrub = 0;
    int          lat;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_saddr = '0;
    logic [15:0] exp_fixes = FIX_INIT;
    logic        we_exp = 1'b0;
    int          we_cyc = 0;
    logic [7:0]  we_addr;
    logic [39:0] we_data, sw;
    logic [31:0] sfix;

    always @(negedge clk) begin
        if (tb_wr_en) shadow[tb_wr_addr] = tb_wr_data;
        if (mon_en && rst_n) begin
            if (cyc > 0 && cyc % int'(SCRUB_INT) == 0) wrap_q.push_back(cyc);
            if (host_gnt) begin
                hnew.cyc  = cyc;
                hnew.addr = host_addr;
                hnew.data = fix_word(shadow[host_addr][31:0], shadow[host_addr][39:32]);
                hnew.corr = (hnew.data != shadow[host_addr][31:0]);
                hq.push_back(hnew);
            end
            if (hq.size() != 0 && hq[0].cyc == cyc - 2) check("sec_r_in_chk", sec_r, 1'b1);
            if (mem_re) begin
                if (hq.size() != 0 && hq[0].cyc == cyc - 1) begin
                    check("host_mem_addr", mem_addr, hq[0].addr);
                end else begin
                    n_scrub++;
                    check("scrub_addr", mem_addr, exp_saddr);
                    if (wrap_q.size() == 0) begin
                        fail("scrub_without_timer", cyc, 0);
                    end else begin
                        lat = cyc - wrap_q.pop_front();
                        check("scrub_latency_ok", (lat >= 1 && lat <= 10), 1'b1);
                    end
                    sw   = shadow[exp_saddr];
                    sfix = fix_word(sw[31:0], sw[39:32]);
                    if (sfix != sw[31:0]) begin
                        we_exp  = 1'b1;
                        we_cyc  = cyc + 2;
                        we_addr = exp_saddr;
                        we_data = {sw[39:32], sfix};
                        shadow[exp_saddr] = we_data;
                        if (exp_fixes != 16'hFFFF) exp_fixes++;
                    end
                    exp_saddr = 8'((int'(exp_saddr) + 1) % int'(DEPTH));
                end
            end
            if (host_rvalid) begin
                if (hq.size() == 0) begin
                    fail("rvalid_unexpected", cyc, 0);
                end else begin
                    hcur = hq.pop_front();
                    check("rvalid_latency", cyc - hcur.cyc, 3);
                    check("host_rdata", host_rdata, hcur.data);
                    check("host_corr", host_corr, hcur.corr);
                end
            end
            if (mem_we) begin
                if (!we_exp || cyc != we_cyc) begin
                    fail("mem_we_unexpected", cyc, we_cyc);
                end else begin
                    check("wb_addr", mem_addr, we_addr);
                    check("wb_wdata", mem_wdata, we_data);
                    check("scrub_fixes", scrub_fixes, exp_fixes);
                end
                we_exp = 1'b0;
            end else if (we_exp && cyc >= we_cyc) begin
                fail("mem_we_missing", cyc, we_cyc);
                we_exp = 1'b0;
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [39:0] w);
        tb_wr_en   = 1'b1;
        tb_wr_addr = a;
        tb_wr_data = w;
        @(posedge clk);
        #1;
        tb_wr_en = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output int gcyc);
        int t;
        @(posedge clk);
        #1;
        host_req  = 1'b1;
        host_addr = a;
        gcyc = -1;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (host_gnt) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) fail("host_gnt_timeout", t, 0);
        else          check("host_wait_bounded", t <= 6, 1'b1);
        @(posedge clk);
        #1;
        host_req = 1'b0;
    endtask

    task automatic wait_rvalid(output bit got);
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (host_rvalid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("rvalid_timeout", cyc, 0);
    endtask

    task automatic check_reset_outputs(input logic [15:0] fixes);
        check("rst_host_gnt", host_gnt, 1'b0);
        check("rst_host_rvalid", host_rvalid, 1'b0);
        check("rst_host_rdata", host_rdata, 32'h0);
        check("rst_host_corr", host_corr, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h0);
        check("rst_mem_wdata", mem_wdata, 40'h0);
        check("rst_sec_id", sec_id, 32'h0);
        check("rst_sec_ic", sec_ic, 8'h0);
        check("rst_sec_r", sec_r, 1'b0);
        check("rst_scrub_fixes", scrub_fixes, fixes);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  chk;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_corr;
    } vec_t;

    vec_t vec [5];

    initial begin
        int  g, prev, gap, n_before;
        bit  got, found;
        logic [7:0] c;

        vec[0] = '{8'h05, 8'h00, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vec[1] = '{8'h21, 8'h87, 32'h00000000, 32'h00000080, 1'b1};
        vec[2] = '{8'h42, 8'h9F, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1};
        vec[3] = '{8'h63, 8'h47, 32'h12345678, 32'h12345678, 1'b0};
        vec[4] = '{8'hFF, 8'h80, 32'h00000001, 32'h00000000, 1'b1};

        rst_n     = 1'b0;
        host_req  = 1'b0;
        host_addr = '0;
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            c = 8'($urandom_range(0, 31));
            if (a < int'(DEPTH)) c[7] = (a != 2);
            else                 c[7] = 1'($urandom_range(0, 1));
            poke(8'(a), {c, 32'($urandom)});
        end
        for (int i = 0; i < 5; i++) poke(vec[i].addr, {vec[i].chk, vec[i].data});

        check_reset_outputs(FIX_INIT);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table-driven host reads; exact gnt -> mem_re -> rvalid timing.
        for (int i = 0; i < 5; i++) begin
            host_read(vec[i].addr, g);
            @(negedge clk);
            check("tbl_mem_re", mem_re, 1'b1);
            check("tbl_mem_addr", mem_addr, vec[i].addr);
            wait_rvalid(got);
            if (got) begin
                check("tbl_latency", cyc - g, 3);
                check("tbl_rdata", host_rdata, vec[i].exp_data);
                check("tbl_corr", host_corr, vec[i].exp_corr);
            end
        end

        // Host request held continuously: scrubs slot in between host grants.
        n_before = n_scrub;
        prev = -1;
        @(posedge clk);
        #1;
        host_req  = 1'b1;
        host_addr = 8'($urandom_range(0, 15));
        for (int k = 0; k < 14; k++) begin
            g = -1;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (host_gnt) begin
                    g = cyc;
                    break;
                end
            end
            if (g < 0) begin
                fail("arb_gnt_timeout", cyc, 0);
                break;
            end
            if (prev >= 0) begin
                gap = g - prev;
                check("arb_gap_legal", (gap == 3 || gap == 6 || gap == 7), 1'b1);
            end
            prev = g;
            @(posedge clk);
            #1;
            host_addr = 8'($urandom_range(0, 15));
        end
        host_req = 1'b0;
        check("arb_scrub_interleaved", n_scrub > n_before, 1'b1);

        // Randomized host traffic.
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            host_read(8'($urandom_range(0, 15)), g);
        end

        repeat (12) @(negedge clk);
        check("host_reads_drained", hq.size(), 0);
        check("fixes_saturated", scrub_fixes, 16'hFFFF);
        check("scrubs_walked", n_scrub >= 5, 1'b1);

        // Reset while a flagged scrub word is in CHK.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        found  = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (mem_re && mem_addr != 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            fail("rst_scrub_timeout", cyc, 0);
        end else begin
            @(negedge clk);
            check("rst_in_chk_sec_r", sec_r, 1'b1);
            #1;
            rst_n = 1'b0;
            #1;
            check_reset_outputs(FIX_INIT);
            repeat (3) begin
                @(negedge clk);
                check("rst_hold_no_we", mem_we, 1'b0);
            end
            #2;
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("post_rst_no_we", mem_we, 1'b0);
                check("post_rst_no_rvalid", host_rvalid, 1'b0);
            end
            @(posedge clk);
            #1;
            host_req  = 1'b1;
            host_addr = 8'h21;
            @(negedge clk);
            check("post_rst_idle_gnt", host_gnt, 1'b1);
            @(posedge clk);
            #1;
            host_req = 1'b0;
            wait_rvalid(got);
            if (got) check("post_rst_rdata", host_rdata, 32'h00000080);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
